// File: rtl/rsa_modexp.sv
// ============================================================================
// Module   : rsa_modexp
// Purpose  : Square-and-multiply modular exponentiation (plain^exponent mod
//            modulus) built on an MSB-first interleaved modular multiplier.
//            Optional macro RSA_MODEXP_ERR_EN adds an err output and an early
//            exit for modulus < 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_modexp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] plain,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             eoc,
`ifdef RSA_MODEXP_ERR_EN
    output logic             err,
`endif
    output logic             busy
);

    localparam int              c_BW      = $clog2(WIDTH);
    localparam logic [c_BW-1:0] c_BIT_MSB = c_BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_REDUCE = 3'd1,
        S_SQUARE = 3'd2,
        S_MULT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_plain;
    logic [WIDTH-1:0]  r_exp;
    logic [WIDTH-1:0]  r_mod;
    logic [WIDTH:0]    r_acc;
    logic [WIDTH-1:0]  r_r;
    logic [WIDTH-1:0]  r_p;
    logic [c_BW-1:0]   r_bit;
    logic [c_BW-1:0]   r_k;

    logic              w_mul_bit;
    logic [WIDTH-1:0]  w_addend;
    logic [WIDTH:0]    w_mod_ext;
    logic [WIDTH:0]    w_dbl;
    logic [WIDTH:0]    w_red1;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_red2;
    logic [WIDTH-1:0]  w_prod;
    logic              w_mod_small;

    // REDUCE multiplies 1*plain; SQUARE uses R as both operands; MULT is R*P.
    always_comb begin
        w_mul_bit = 1'b0;
        w_addend  = '0;
        case (r_state)
            S_REDUCE: begin
                w_mul_bit = r_plain[r_bit];
                w_addend  = WIDTH'(1);
            end
            S_SQUARE: begin
                w_mul_bit = r_r[r_bit];
                w_addend  = r_r;
            end
            S_MULT: begin
                w_mul_bit = r_r[r_bit];
                w_addend  = r_p;
            end
            default: begin
                w_mul_bit = 1'b0;
                w_addend  = '0;
            end
        endcase
    end

    // Accumulator stays below modulus, so one extra bit absorbs 2R and R+addend.
    assign w_mod_ext   = {1'b0, r_mod};
    assign w_dbl       = r_acc << 1;
    assign w_red1      = (w_dbl >= w_mod_ext) ? (w_dbl - w_mod_ext) : w_dbl;
    assign w_sum       = w_mul_bit ? (w_red1 + {1'b0, w_addend}) : w_red1;
    assign w_red2      = (w_sum >= w_mod_ext) ? (w_sum - w_mod_ext) : w_sum;
    assign w_prod      = w_red2[WIDTH-1:0];
    assign w_mod_small = (r_mod < WIDTH'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_plain <= '0;
            r_exp   <= '0;
            r_mod   <= '0;
            r_acc   <= '0;
            r_r     <= '0;
            r_p     <= '0;
            r_bit   <= '0;
            r_k     <= '0;
            result  <= '0;
            eoc     <= 1'b0;
            busy    <= 1'b0;
`ifdef RSA_MODEXP_ERR_EN
            err     <= 1'b0;
`endif
        end else if (en) begin
            if (!clr_n) begin
                r_state <= S_LOAD;
                r_plain <= plain;
                r_exp   <= exponent;
                r_mod   <= modulus;
                r_acc   <= '0;
                r_r     <= '0;
                r_p     <= '0;
                r_bit   <= '0;
                r_k     <= '0;
                result  <= '0;
                eoc     <= 1'b0;
                busy    <= 1'b0;
`ifdef RSA_MODEXP_ERR_EN
                err     <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_state <= S_REDUCE;
                        r_acc   <= '0;
                        r_bit   <= c_BIT_MSB;
                        busy    <= 1'b1;
                    end
                    S_REDUCE: begin
`ifdef RSA_MODEXP_ERR_EN
                        if (w_mod_small) begin
                            r_state <= S_DONE;
                            result  <= '0;
                            eoc     <= 1'b1;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else
`endif
                        if (r_bit == '0) begin
                            r_p     <= w_prod;
                            r_r     <= w_mod_small ? '0 : WIDTH'(1);
                            r_acc   <= '0;
                            r_bit   <= c_BIT_MSB;
                            r_k     <= c_BIT_MSB;
                            r_state <= S_SQUARE;
                        end else begin
                            r_acc <= w_red2;
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                    S_SQUARE, S_MULT: begin
                        if (r_bit == '0) begin
                            r_r   <= w_prod;
                            r_acc <= '0;
                            r_bit <= c_BIT_MSB;
                            if (r_state == S_SQUARE && r_exp[r_k]) begin
                                r_state <= S_MULT;
                            end else if (r_k == '0) begin
                                r_state <= S_DONE;
                                result  <= w_mod_small ? '0 : w_prod;
                                eoc     <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                r_k     <= r_k - 1'b1;
                                r_state <= S_SQUARE;
                            end
                        end else begin
                            r_acc <= w_red2;
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_LOAD;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp.sv
// ============================================================================
// Module   : tb_rsa_modexp
// Purpose  : Self-checking bench for rsa_modexp against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsa_modexp;

    localparam int W     = 8;
    localparam int LIMIT = 5000;

    logic         clk;
    logic         rst;
    logic         en;
    logic         clr_n;
    logic [W-1:0] plain;
    logic [W-1:0] exponent;
    logic [W-1:0] modulus;
    logic [W-1:0] result;
    logic         eoc;
    logic         busy;
`ifdef RSA_MODEXP_ERR_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr_n    (clr_n),
        .plain    (plain),
        .exponent (exponent),
        .modulus  (modulus),
        .result   (result),
        .eoc      (eoc),
`ifdef RSA_MODEXP_ERR_EN
        .err      (err),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_modexp(logic [W-1:0] p, logic [W-1:0] e, logic [W-1:0] m);
        longint r, b;
        if (m < 2) return '0;
        r = 1;
        b = longint'(p) % longint'(m);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % longint'(m);
            b = (b * b) % longint'(m);
        end
        return W'(r);
    endfunction

    function automatic int ref_lat(logic [W-1:0] e, logic [W-1:0] m);
        int pc;
`ifdef RSA_MODEXP_ERR_EN
        if (m < 2) return 2;
`endif
        pc = 0;
        for (int i = 0; i < W; i++) pc += int'(e[i]);
        return 1 + W * (1 + W + pc);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: captured operands and count of qualifying edges since capture.
    logic [W-1:0] m_p, m_e, m_m;
    int           m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p   <= '0;
            m_e   <= '0;
            m_m   <= '0;
            m_cnt <= 0;
        end else if (en) begin
            if (!clr_n) begin
                m_p   <= plain;
                m_e   <= exponent;
                m_m   <= modulus;
                m_cnt <= 0;
            end else if (m_cnt < ref_lat(m_e, m_m)) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    int  cmp_lat;
    logic cmp_done;
    always @(negedge clk) begin
        if (!rst) begin
            cmp_lat  = ref_lat(m_e, m_m);
            cmp_done = (m_cnt >= cmp_lat);
            chk("result", result, cmp_done ? ref_modexp(m_p, m_e, m_m) : 0);
            chk("eoc", eoc, cmp_done);
            chk("busy", busy, (m_cnt >= 1) && (m_cnt < cmp_lat));
`ifdef RSA_MODEXP_ERR_EN
            chk("err", err, cmp_done && (m_m < 2));
`endif
        end
    end

    task automatic start(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] m);
        @(negedge clk);
        plain    = p;
        exponent = e;
        modulus  = m;
        en       = 1'b1;
        clr_n    = 1'b0;
        @(negedge clk);
        clr_n    = 1'b1;
    endtask

    task automatic run_to_eoc(input int pause_at, input int pause_len, input int exp_edge,
                              input logic [W-1:0] exp_res, input string name);
        int n, cyc, left;
        n    = 0;
        cyc  = 0;
        left = pause_len;
        while (!eoc && cyc < LIMIT) begin
            if (n == pause_at && left > 0) begin
                en = 1'b0;
                left--;
            end else begin
                en = 1'b1;
            end
            @(posedge clk);
            if (en) n++;
            cyc++;
            @(negedge clk);
        end
        en = 1'b1;
        chk({name, "_eoc_edge"}, cyc >= LIMIT ? -1 : n, exp_edge);
        chk({name, "_result"}, result, exp_res);
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        clr_n    = 1'b1;
        plain    = '0;
        exponent = '0;
        modulus  = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_result", result, 0);
        chk("reset_eoc", eoc, 0);
        chk("reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        start(8'd5, 8'd3, 8'd13);
        run_to_eoc(-1, 0, 89, 8'd8, "p5e3m13");
        repeat (4) @(negedge clk);

        start(8'd200, 8'd0, 8'd7);
        run_to_eoc(-1, 0, 73, 8'd1, "p200e0m7");

        start(8'd200, 8'd5, 8'd7);
        run_to_eoc(-1, 0, 89, 8'd2, "p200e5m7");

        start(8'd5, 8'd3, 8'd13);
        run_to_eoc(20, 10, 89, 8'd8, "paused");

        // Abort after 39 edges, restart on edge 40 with new operands.
        start(8'd5, 8'd3, 8'd13);
        repeat (39) @(negedge clk);
        plain    = 8'd3;
        exponent = 8'd4;
        modulus  = 8'd11;
        clr_n    = 1'b0;
        @(negedge clk);
        clr_n    = 1'b1;
        chk("abort_result", result, 0);
        chk("abort_eoc", eoc, 0);
        chk("abort_busy", busy, 0);
        run_to_eoc(-1, 0, 81, 8'd4, "p3e4m11");

        // Async reset while in MULT (edges 66..73 for exponent 3).
        start(8'd5, 8'd3, 8'd13);
        repeat (68) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_result", result, 0);
        chk("arst_eoc", eoc, 0);
        chk("arst_busy", busy, 0);
        #1 rst = 1'b0;

        start(8'd9, 8'hA5, 8'd1);
`ifdef RSA_MODEXP_ERR_EN
        run_to_eoc(-1, 0, 2, 8'd0, "mod1");
        chk("mod1_err", err, 1);
`else
        run_to_eoc(-1, 0, 105, 8'd0, "mod1");
`endif

        for (int it = 0; it < 8; it++) begin
            logic [W-1:0] rp, re, rm;
            rp = W'($urandom);
            re = W'($urandom);
            rm = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1)) : W'($urandom);
            start(rp, re, rm);
            run_to_eoc($urandom_range(1, 60), $urandom_range(0, 5), ref_lat(re, rm),
                       ref_modexp(rp, re, rm), "rand");
            repeat (2) @(negedge clk);
            en = 1'b0;
            repeat (2) @(negedge clk);
            en = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rsa_modexp.md
RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (supported range 4..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port en  input  1  enable from rsa_en_logic en_rsa; low freezes all state.
REQ-005 SHALL have port clr_n  input  1  synchronous active-low clear from rsa_en_logic rst_rsa.
REQ-006 SHALL have port plain  input  WIDTH  base operand.
REQ-007 SHALL have port exponent  input  WIDTH  exponent operand.
REQ-008 SHALL have port modulus  input  WIDTH  modulus operand.
REQ-009 SHALL have port result  output  WIDTH  plain^exponent mod modulus.
REQ-010 SHALL have port eoc  output  1  end of computation; drives rsa_en_logic eoc_int.
REQ-011 SHALL have port busy  output  1  high in REDUCE, SQUARE and MULT.

Function
REQ-012 SHALL implement states LOAD, REDUCE, SQUARE, MULT and DONE.
REQ-013 SHALL act on a clock edge only when en=1; when en=0, state, counters, registers and outputs hold.
REQ-014 SHALL, on an edge with en=1 and clr_n=0 in any state, go to LOAD, clear eoc, busy and result, and capture plain, exponent and modulus.
REQ-015 SHALL, on an edge with en=1 and clr_n=1 in LOAD, go to REDUCE with accumulator R=0; operands then stay frozen until the next LOAD.
REQ-016 SHALL compute in REDUCE the value P = plain mod modulus as the interleaved modular product 1*plain, one plain bit per edge from MSB, over WIDTH edges; then set R=1 mod modulus and exponent bit index k=WIDTH-1.
REQ-017 SHALL perform each interleaved modular multiply step as R=2R, subtract modulus if R>=modulus, add addend if multiplier bit set, subtract modulus if R>=modulus; internal width is WIDTH+1 bits, with no overflow.
REQ-018 SHALL perform R=R*R mod modulus in SQUARE over WIDTH edges; then go to MULT if exponent[k]=1, else decrement k.
REQ-019 SHALL perform R=R*P mod modulus in MULT over WIDTH edges, then decrement k.
REQ-020 SHALL go to DONE after bit k=0 has completed, setting result=R and eoc=1 on the same edge.
REQ-021 SHALL hold result and eoc in DONE until clr_n=0 (with en=1) or rst.
REQ-022 SHALL assert eoc on qualifying edge number 1+WIDTH*(1+WIDTH+popcount(exponent)), where edge 1 is the edge that leaves LOAD; edges with en=0 are not counted.
REQ-023 SHALL return result=1 for exponent=0 and modulus>=2.
REQ-024 SHALL return result=0 whenever modulus<2.
REQ-025 SHALL accept plain>=modulus; the REDUCE phase makes the result correct.

Reset
REQ-026 SHALL, while rst=1, immediately force state=LOAD, result=0, eoc=0, busy=0, and all counters and accumulators to 0, independent of clk and en.
REQ-027 SHALL, after rst is released, require one edge with clr_n=0 before a new computation starts, so that operands are captured.

Configuration
REQ-028 SHALL, with macro RSA_MODEXP_ERR_EN defined, add output port err (1 bit): a capture with modulus<2 then skips REDUCE, SQUARE and MULT, reaches DONE on edge 2 with result=0, eoc=1 and err=1; err is cleared with eoc.
REQ-029 SHALL, without RSA_MODEXP_ERR_EN, have no err port; for modulus<2 the block runs the full REQ-022 latency and then forces result=0.

Verification
REQ-030 SHALL be checked with WIDTH=8, plain=5, exponent=3, modulus=13 -> result=8, eoc rises on edge 89, busy high from edge 1 to edge 88.
REQ-031 SHALL be checked with plain=200, exponent=0, modulus=7 -> result=1, eoc on edge 73; and with plain=200, exponent=5, modulus=7 -> result=2, eoc on edge 89.
REQ-032 SHALL be checked with en=0 for 10 cycles in the middle of SQUARE for 5^3 mod 13 -> all outputs frozen; eoc on edge 89 counting only en=1 edges; result=8.
REQ-033 SHALL be checked with clr_n=0 at edge 40, then restart with 3^4 mod 11 -> eoc=0 and result=0 immediately; final result=4.
REQ-034 SHALL be checked with rst=1 pulsed asynchronously mid-MULT -> result=0, eoc=0 and busy=0 without a clock edge.
REQ-035 SHALL be checked with modulus=1 -> result=0; with the macro defined, err=1 and eoc on edge 2; without it, eoc on the edge given by REQ-022.
